// File: rtl/store_align_unit.sv
// Store lane aligner to data SRAM: 1-cycle latency, one-entry output register, back-to-back under m_ready.
// Holds outputs while m_ready=0 (s_ready drops); flushM clears the entry. STORE_ADES_EN enables misaligned-store exceptions.
module store_align_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        sbM,
    input  logic        shM,
    input  logic        swM,
    input  logic [31:0] addrM,
    input  logic [31:0] wdataM,
    input  logic        flushM,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    output logic        adesM,
    output logic [31:0] badvaddrM,
    output logic [31:0] store_cnt
);

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_wen;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_cnt;

    logic        w_accept;
    logic        w_onehot;
    logic        w_misalign;
    logic        w_legal;
    logic        w_complete;
    logic [3:0]  w_wen;
    logic [31:0] w_wdata;

    assign w_accept   = s_valid && s_ready;
    assign w_onehot   = (2'(sbM) + 2'(shM) + 2'(swM)) == 2'd1;
    assign w_legal    = w_onehot && !w_misalign;
    assign w_complete = (r_state == ST_FULL) && m_ready && !flushM;

    always_comb begin
        w_wen   = 4'b0000;
        w_wdata = wdataM;
        if (sbM) begin
            w_wen   = 4'b0001 << addrM[1:0];
            w_wdata = {4{wdataM[7:0]}};
        end else if (shM) begin
            w_wen   = addrM[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{wdataM[15:0]}};
        end else if (swM) begin
            w_wen   = 4'b1111;
            w_wdata = wdataM;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Flush wins over a same-cycle completion; a legal accept keeps FULL with no bubble.
    always_comb begin
        w_state_nxt = r_state;
        if (flushM) begin
            w_state_nxt = ST_EMPTY;
        end else if (w_accept && w_legal) begin
            w_state_nxt = ST_FULL;
        end else if (w_complete) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    always_comb begin
        m_valid         = (r_state == ST_FULL);
        s_ready         = resetn && !flushM && ((r_state == ST_EMPTY) || m_ready);
        data_sram_wen   = (r_state == ST_FULL) ? r_wen : 4'b0000;
        data_sram_addr  = r_addr;
        data_sram_wdata = r_wdata;
        store_cnt       = r_cnt;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wen   <= 4'b0000;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_cnt   <= 32'h0;
        end else begin
            if (w_accept && w_legal) begin
                r_wen   <= w_wen;
                r_addr  <= {addrM[31:2], 2'b00};
                r_wdata <= w_wdata;
            end
            if (w_complete) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

`ifdef STORE_ADES_EN
    logic        r_ades;
    logic [31:0] r_badvaddr;

    assign w_misalign = (shM && addrM[0]) || (swM && (addrM[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ades     <= 1'b0;
            r_badvaddr <= 32'h0;
        end else begin
            r_ades <= w_accept && w_onehot && w_misalign;
            if (w_accept && w_onehot && w_misalign) begin
                r_badvaddr <= addrM;
            end
        end
    end

    assign adesM     = r_ades;
    assign badvaddrM = r_badvaddr;
`else
    assign w_misalign = 1'b0;
    assign adesM      = 1'b0;
    assign badvaddrM  = 32'h0;
`endif

endmodule

// File: tb/tb_store_align_unit.sv
// Bench for store_align_unit: vector table plus hand sequences, write contents checked by a scoreboard queue.
module tb_store_align_unit;

    logic        clk = 1'b0;
    logic        resetn, s_valid, s_ready, sbM, shM, swM, flushM, m_valid, m_ready, adesM;
    logic [31:0] addrM, wdataM, data_sram_addr, data_sram_wdata, badvaddrM, store_cnt;
    logic [3:0]  data_sram_wen;

    store_align_unit dut (
        .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(s_ready),
        .sbM(sbM), .shM(shM), .swM(swM), .addrM(addrM), .wdataM(wdataM),
        .flushM(flushM), .m_valid(m_valid), .m_ready(m_ready),
        .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .adesM(adesM), .badvaddrM(badvaddrM),
        .store_cnt(store_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sb, sh, sw;
        logic [31:0] addr, wdata;
        logic        wr, ades;
        logic [3:0]  wen;
        logic [31:0] waddr, wdat;
    } vec_t;

    typedef struct packed {
        logic [3:0]  wen;
        logic [31:0] addr, wdata;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model_cnt = 0;
    int          vld_run = 0;
    int          last_run = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic sb, sh, sw, input logic [31:0] a, d,
                                input logic wr, ades, input logic [3:0] wen,
                                input logic [31:0] wa, wd);
        return '{sb, sh, sw, a, d, wr, ades, wen, wa, wd};
    endfunction

    // Scoreboard side: every completed handshake must match the oldest accepted store.
    always @(negedge clk) begin
        if (!resetn) begin
            model_cnt = 0;
            exp_q.delete();
            vld_run = 0;
        end else begin
            chk("store_cnt", store_cnt, model_cnt);
            if (!m_valid) chk("idle_wen", 32'(data_sram_wen), 32'h0);
            if (m_valid) vld_run++;
            else begin
                if (vld_run != 0) last_run = vld_run;
                vld_run = 0;
            end
            if (m_valid && m_ready && !flushM) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got wen=%b addr=0x%08h, expected none", data_sram_wen, data_sram_addr);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_wen", 32'(data_sram_wen), 32'(e.wen));
                    chk("wr_addr", data_sram_addr, e.addr);
                    chk("wr_wdata", data_sram_wdata, e.wdata);
                end
                model_cnt++;
            end
        end
    end

    // Called just after a posedge; returns on the posedge at which the request is taken.
    task automatic send(input vec_t v);
        int waited = 0;
        #2;
        s_valid = 1'b1; sbM = v.sb; shM = v.sh; swM = v.sw; addrM = v.addr; wdataM = v.wdata;
        @(negedge clk);
        while (!s_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!s_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: s_ready stayed 0, expected 1 within 20 cycles");
            s_valid = 1'b0;
        end
        @(posedge clk);
        if (waited < 20 && v.wr) exp_q.push_back('{v.wen, v.waddr, v.wdat});
    endtask

    task automatic idle();
        #2;
        s_valid = 1'b0; sbM = 1'b0; shM = 1'b0; swM = 1'b0; addrM = 32'h0; wdataM = 32'h0;
    endtask

    vec_t        tbl[13];
    logic [31:0] snap;

    initial begin
        tbl[0]  = mk(1,0,0, 32'h1000, 32'h11223344, 1,0, 4'b0001, 32'h1000, 32'h44444444);
        tbl[1]  = mk(1,0,0, 32'h1001, 32'h000000C3, 1,0, 4'b0010, 32'h1000, 32'hC3C3C3C3);
        tbl[2]  = mk(1,0,0, 32'h1002, 32'hFFFFFF5A, 1,0, 4'b0100, 32'h1000, 32'h5A5A5A5A);
        tbl[3]  = mk(1,0,0, 32'h1003, 32'h000000A5, 1,0, 4'b1000, 32'h1000, 32'hA5A5A5A5);
        tbl[4]  = mk(0,1,0, 32'h2000, 32'hCAFEF00D, 1,0, 4'b0011, 32'h2000, 32'hF00DF00D);
        tbl[5]  = mk(0,1,0, 32'h2002, 32'h1234BEEF, 1,0, 4'b1100, 32'h2000, 32'hBEEFBEEF);
        tbl[6]  = mk(0,0,1, 32'h2004, 32'hDEADBEEF, 1,0, 4'b1111, 32'h2004, 32'hDEADBEEF);
        tbl[9]  = mk(0,0,0, 32'h4000, 32'h55555555, 0,0, 4'b0000, 32'h0, 32'h0);
        tbl[10] = mk(1,0,1, 32'h4004, 32'h66666666, 0,0, 4'b0000, 32'h0, 32'h0);
        tbl[11] = mk(1,0,0, 32'hFFFFFFFE, 32'h0000007E, 1,0, 4'b0100, 32'hFFFFFFFC, 32'h7E7E7E7E);
`ifdef STORE_ADES_EN
        tbl[7]  = mk(0,1,0, 32'h2001, 32'h00005678, 0,1, 4'b0000, 32'h0, 32'h0);
        tbl[8]  = mk(0,0,1, 32'h3001, 32'h87654321, 0,1, 4'b0000, 32'h0, 32'h0);
        tbl[12] = mk(0,1,0, 32'h2003, 32'h0000ABCD, 0,1, 4'b0000, 32'h0, 32'h0);
`else
        tbl[7]  = mk(0,1,0, 32'h2001, 32'h00005678, 1,0, 4'b0011, 32'h2000, 32'h56785678);
        tbl[8]  = mk(0,0,1, 32'h3001, 32'h87654321, 1,0, 4'b1111, 32'h3000, 32'h87654321);
        tbl[12] = mk(0,1,0, 32'h2003, 32'h0000ABCD, 1,0, 4'b1100, 32'h2000, 32'hABCDABCD);
`endif

        // Reset with a request pending: s_ready must stay low, outputs must clear.
        resetn = 1'b0; s_valid = 1'b1; sbM = 1'b0; shM = 1'b0; swM = 1'b1;
        addrM = 32'h10; wdataM = 32'h1; flushM = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        chk("reset_s_ready", 32'(s_ready), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("reset_m_valid", 32'(m_valid), 32'h0);
        chk("reset_wen", 32'(data_sram_wen), 32'h0);
        chk("reset_addr", data_sram_addr, 32'h0);
        chk("reset_wdata", data_sram_wdata, 32'h0);
        chk("reset_ades", 32'(adesM), 32'h0);
        chk("reset_badvaddr", badvaddrM, 32'h0);
        chk("reset_cnt", store_cnt, 32'h0);
        @(posedge clk);
        #2 resetn = 1'b1; s_valid = 1'b0; swM = 1'b0;
        @(posedge clk);

        for (int i = 0; i < 13; i++) begin
            snap = model_cnt;
            send(tbl[i]);
            idle();
            @(negedge clk);
            chk($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].wr));
            chk($sformatf("vec%0d_ades", i), 32'(adesM), 32'(tbl[i].ades));
            if (tbl[i].ades) chk($sformatf("vec%0d_badvaddr", i), badvaddrM, tbl[i].addr);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_ades_gone", i), 32'(adesM), 32'h0);
            chk($sformatf("vec%0d_cnt", i), store_cnt, snap + 32'(tbl[i].wr));
            @(posedge clk);
        end

        // sh then sw back-to-back; the sw is then held for 3 cycles with m_ready low.
        send(tbl[5]);
        send(tbl[6]);
        idle();
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_m_valid", 32'(m_valid), 32'h1);
            chk("hold_s_ready", 32'(s_ready), 32'h0);
            chk("hold_wen", 32'(data_sram_wen), 32'hF);
            chk("hold_addr", data_sram_addr, 32'h2004);
            chk("hold_wdata", data_sram_wdata, 32'hDEADBEEF);
        end
        @(posedge clk);
        #2 m_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);

        // Three back-to-back words: one unbroken 3-cycle m_valid run.
        last_run = 0;
        snap = model_cnt;
        send(mk(0,0,1, 32'h5000, 32'hA0000001, 1,0, 4'b1111, 32'h5000, 32'hA0000001));
        send(mk(0,0,1, 32'h5004, 32'hA0000002, 1,0, 4'b1111, 32'h5004, 32'hA0000002));
        send(mk(0,0,1, 32'h5008, 32'hA0000003, 1,0, 4'b1111, 32'h5008, 32'hA0000003));
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("b2b_run", 32'(last_run), 32'd3);
        chk("b2b_cnt", store_cnt, snap + 32'd3);

        // Flush while FULL with m_ready high: dropped, not counted.
        snap = model_cnt;
        send(mk(0,0,1, 32'h6000, 32'h12345678, 1,0, 4'b1111, 32'h6000, 32'h12345678));
        idle();
        flushM = 1'b1;
        @(negedge clk);
        chk("flush_s_ready", 32'(s_ready), 32'h0);
        @(posedge clk);
        #2 flushM = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_m_valid", 32'(m_valid), 32'h0);
        chk("flush_cnt", store_cnt, snap);
        @(posedge clk);

        // Reset while FULL discards the pending write.
        send(mk(0,0,1, 32'h7000, 32'h0BADF00D, 1,0, 4'b1111, 32'h7000, 32'h0BADF00D));
        idle();
        m_ready = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_full_s_ready", 32'(s_ready), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_full_m_valid", 32'(m_valid), 32'h0);
        chk("rst_full_wen", 32'(data_sram_wen), 32'h0);
        chk("rst_full_addr", data_sram_addr, 32'h0);
        chk("rst_full_wdata", data_sram_wdata, 32'h0);
        chk("rst_full_ades", 32'(adesM), 32'h0);
        chk("rst_full_badvaddr", badvaddrM, 32'h0);
        chk("rst_full_cnt", store_cnt, 32'h0);
        @(posedge clk);
        #2 resetn = 1'b1; m_ready = 1'b1;
        @(posedge clk);
        send(tbl[3]);
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("post_reset_cnt", store_cnt, 32'h1);

        chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
